// File: rtl/inst_fetch_queue.sv
// ============================================================================
// Module   : inst_fetch_queue
// Brief    : Continuous-prefetch instruction fetch front end. It owns the
//            fetch PC, reads a 1-cycle-latency memory and buffers the
//            PC-tagged words in a FIFO that feeds decode over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_queue #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       mem_rd,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_data,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_STALL = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    localparam logic [CNT_W:0]    c_DEPTH_OCC = (CNT_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_PC_STEP   = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_fifo_instr [DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc    [DEPTH];

    logic [CNT_W:0]    w_occupancy;
    logic [1:0]        w_state;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_not_empty;

    // Occupancy counts the slot already reserved by a read still in flight.
    assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_not_empty = (r_count != '0);

    always_comb begin
        w_state = c_ST_RUN;
        if (redirect) begin
            w_state = c_ST_FLUSH;
        end else if (w_occupancy >= c_DEPTH_OCC) begin
            w_state = c_ST_STALL;
        end
    end

    assign w_issue  = !rst && (w_state == c_ST_RUN);
    assign w_push   = r_inflight && !redirect && !rst;
    assign w_pop    = out_valid && out_ready;

    assign mem_rd    = w_issue;
    assign mem_addr  = r_fetch_pc;
    assign out_valid = w_not_empty && !redirect;
    assign out_instr = w_not_empty ? r_fifo_instr[r_rd_ptr] : '0;
    assign out_pc    = w_not_empty ? r_fifo_pc[r_rd_ptr]    : '0;
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else if (redirect) begin
            // Anything queued or returning belongs to the abandoned path.
            r_fetch_pc <= redirect_pc;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_fetch_pc    <= r_fetch_pc + c_PC_STEP;
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
            end else begin
                r_inflight <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= mem_data;
            r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// ============================================================================
// Module   : tb_inst_fetch_queue
// Brief    : Directed and randomised checks of inst_fetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_queue;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_ready;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic [2:0]        count;

    logic              redirect2;
    logic [ADDR_W-1:0] redirect_pc2;
    logic              out_ready2;
    logic              mem_rd2;
    logic [ADDR_W-1:0] mem_addr2;
    logic [DATA_W-1:0] mem_data2;
    logic              out_valid2;
    logic [DATA_W-1:0] out_instr2;
    logic [ADDR_W-1:0] out_pc2;
    logic [2:0]        count2;

    int n_vec;
    int n_err;

    inst_fetch_queue #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(8'h00)
    ) u_dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .count(count)
    );

    inst_fetch_queue #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(8'hF8)
    ) u_dut_wrap (
        .clk(clk), .rst(rst), .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_data(mem_data2),
        .redirect(redirect2), .redirect_pc(redirect_pc2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_instr(out_instr2), .out_pc(out_pc2), .count(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: word at a = 0xA0000000 + a; garbage when not read.
    always @(posedge clk) begin
        mem_data  <= mem_rd  ? (32'hA000_0000 + {24'h0, mem_addr})  : 32'hDEAD_BEEF;
        mem_data2 <= mem_rd2 ? (32'hA000_0000 + {24'h0, mem_addr2}) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into cycle 0 with rst just released.
    task automatic reset_c0();
        rst      = 1'b1;
        redirect = 1'b0;
        next_cyc();
        next_cyc();
        rst = 1'b0;
    endtask

    logic [ADDR_W-1:0] exp_pc;
    logic              prev_rd;
    logic              full_push_seen;
    int                pops;

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = '0;
        out_ready    = 1'b0;
        redirect2    = 1'b0;
        redirect_pc2 = '0;
        out_ready2   = 1'b1;

        // Reset values while rst is held
        next_cyc();
        next_cyc();
        #1;
        check("rst_mem_rd",    64'(mem_rd),    64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_count",     64'(count),     64'h0);
        check("rst_out_instr", 64'(out_instr), 64'h0);
        check("rst_out_pc",    64'(out_pc),    64'h0);

        // 1 + 4: latency and back-to-back stream; wrap instance alongside
        reset_c0();
        out_ready = 1'b1;
        #1;
        check("t1_c0_mem_rd",   64'(mem_rd),   64'h1);
        check("t1_c0_mem_addr", 64'(mem_addr), 64'h00);
        check("t1_c0_valid",    64'(out_valid), 64'h0);
        next_cyc(); #1;
        check("t1_c1_valid",    64'(out_valid), 64'h0);
        check("t1_c1_mem_addr", 64'(mem_addr),  64'h04);
        for (int i = 0; i < 4; i++) begin
            next_cyc(); #1;
            if (i < 3) begin
                check("t1_valid", 64'(out_valid), 64'h1);
                check("t1_pc",    64'(out_pc),    64'(i * 4));
                check("t1_instr", 64'(out_instr), 64'(32'hA000_0000 + i * 4));
            end
            check("t4_valid", 64'(out_valid2), 64'h1);
            check("t4_pc",    64'(out_pc2),    64'((8'hF8 + i * 4) & 8'hFF));
            check("t4_instr", 64'(out_instr2), 64'(32'hA000_0000 + ((8'hF8 + i * 4) & 8'hFF)));
        end

        // 2: backpressure fills the FIFO, then drains without a gap
        reset_c0();
        out_ready = 1'b0;
        repeat (9) next_cyc();
        #1;
        check("t2_count",    64'(count),    64'h4);
        check("t2_mem_rd",   64'(mem_rd),   64'h0);
        check("t2_mem_addr", 64'(mem_addr), 64'h10);
        next_cyc();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cyc();
            #1;
            check("t2_valid", 64'(out_valid), 64'h1);
            check("t2_pc",    64'(out_pc),    64'(i * 4));
        end
        check("t2_instr10", 64'(out_instr), 64'h0000_0000_A000_0010);

        // 3: redirect with three queued and one in flight
        reset_c0();
        out_ready = 1'b0;
        repeat (4) next_cyc();
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        #1;
        check("t3_pre_count", 64'(count),     64'h3);
        check("t3_rd_valid",  64'(out_valid), 64'h0);
        check("t3_rd_mem_rd", 64'(mem_rd),    64'h0);
        next_cyc();
        redirect  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("t3_count0",   64'(count),    64'h0);
        check("t3_mem_addr", 64'(mem_addr), 64'h40);
        check("t3_mem_rd",   64'(mem_rd),   64'h1);
        next_cyc(); #1;
        check("t3_c1_valid", 64'(out_valid), 64'h0);
        next_cyc(); #1;
        check("t3_valid", 64'(out_valid), 64'h1);
        check("t3_pc",    64'(out_pc),    64'h40);
        check("t3_instr", 64'(out_instr), 64'h0000_0000_A000_0040);
        next_cyc(); #1;
        check("t3_pc2",   64'(out_pc),    64'h44);

        // 5: reset mid-stream with two entries queued
        reset_c0();
        out_ready = 1'b0;
        repeat (3) next_cyc();
        rst = 1'b1;
        #1;
        check("t5_pre_count", 64'(count),  64'h2);
        check("t5_rst_mem_rd", 64'(mem_rd), 64'h0);
        next_cyc();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("t5_count",    64'(count),     64'h0);
        check("t5_valid",    64'(out_valid), 64'h0);
        check("t5_instr",    64'(out_instr), 64'h0);
        check("t5_pc",       64'(out_pc),    64'h0);
        check("t5_mem_addr", 64'(mem_addr),  64'h00);
        next_cyc(); #1;
        check("t5_stale_count", 64'(count), 64'h0);
        next_cyc(); #1;
        check("t5_restart_pc",    64'(out_pc),    64'h00);
        check("t5_restart_instr", 64'(out_instr), 64'h0000_0000_A000_0000);

        // 6: random backpressure and redirects against a PC scoreboard
        reset_c0();
        exp_pc         = 8'h00;
        prev_rd        = 1'b0;
        full_push_seen = 1'b0;
        pops           = 0;
        for (int i = 0; i < 1000; i++) begin
            out_ready   = 1'($urandom_range(0, 1));
            redirect    = ($urandom_range(0, 99) < 5);
            redirect_pc = 8'($urandom_range(0, 63) * 4);
            #1;
            if (prev_rd && !redirect && (count == 3'(DEPTH))) full_push_seen = 1'b1;
            if (redirect) begin
                check("t6_redir_valid", 64'(out_valid), 64'h0);
                exp_pc = redirect_pc;
            end else if (out_valid && out_ready) begin
                check("t6_pc",    64'(out_pc),    64'(exp_pc));
                check("t6_instr", 64'(out_instr), 64'(32'hA000_0000 + {24'h0, exp_pc}));
                exp_pc = exp_pc + 8'd4;
                pops++;
            end
            prev_rd = mem_rd;
            next_cyc();
        end
        redirect = 1'b0;
        check("t6_no_full_push", 64'(full_push_seen), 64'h0);
        check("t6_some_pops",    64'(pops > 100),     64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
